// File: rtl/mesh_pkg.sv
// mesh_pkg: header field offsets, broadcast default and destination check for the mesh source bank
package mesh_pkg;
    localparam logic [7:0] BDCST_DEF = 8'hFF;
    function automatic int NXTJP_MSB(int sz);
        return sz - 1;
    endfunction
    function automatic int ROW_MSB(int sz);
        return sz - 9;
    endfunction
    function automatic int COL_MSB(int sz);
        return sz - 13;
    endfunction
    function automatic int MODE_BIT(int sz);
        return sz - 17;
    endfunction
    function automatic logic dest_valid(logic [3:0] row, logic [3:0] col, logic [7:0] nxtjp,
                                        int rows, int colums, logic [7:0] bdcst = BDCST_DEF);
        int r;
        int c;
        r = int'(row);
        c = int'(col);
        return nxtjp == bdcst
            || ((r == 0 || r == rows + 1) && c >= 1 && c <= colums)
            || ((c == 0 || c == colums + 1) && r >= 1 && r <= rows);
    endfunction
endpackage

// File: rtl/mesh_src_fifo.sv
// mesh_src_fifo: one terminal channel FIFO with drop pulses, underflow flag; MESH_SRC_STATS_EN adds drop counters
module mesh_src_fifo #(
    parameter int PCKG_SZ    = 40,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               hdr_ok,
    input  logic               popin,
    input  logic               flush,
    input  logic [PCKG_SZ-1:0] din,
    output logic               full,
    output logic               pndng,
    output logic               hdr_err,
    output logic               ovf,
    output logic               unf_sticky,
    output logic [PCKG_SZ-1:0] dout,
    output logic [7:0]         drop_hdr_cnt,
    output logic [7:0]         drop_ovf_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [PCKG_SZ-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic empty, do_push, do_pop, hdr_drop, ovf_drop;
    always_comb begin
        empty    = count == '0;
        full     = count == CW'(FIFO_DEPTH);
        do_pop   = popin && !empty && !flush;
        do_push  = push && hdr_ok && (!full || popin) && !flush;
        hdr_drop = push && !hdr_ok && !flush;
        ovf_drop = push && hdr_ok && full && !popin && !flush;
    end
    assign pndng = !empty;
    assign dout  = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            unf_sticky <= 1'b0;
            hdr_err    <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            hdr_err <= hdr_drop;
            ovf     <= ovf_drop;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                unf_sticky <= 1'b0;
            end else begin
                wr_ptr     <= wr_ptr + AW'(do_push);
                rd_ptr     <= rd_ptr + AW'(do_pop);
                count      <= count + CW'(do_push) - CW'(do_pop);
                unf_sticky <= unf_sticky || (popin && empty);
            end
        end
    end
    // storage carries no reset; dout is masked while the channel is empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
`ifdef MESH_SRC_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_hdr_cnt <= '0;
            drop_ovf_cnt <= '0;
        end else begin
            if (hdr_drop && drop_hdr_cnt != 8'hFF) drop_hdr_cnt <= drop_hdr_cnt + 8'd1;
            if (ovf_drop && drop_ovf_cnt != 8'hFF) drop_ovf_cnt <= drop_ovf_cnt + 8'd1;
        end
    end
`else
    assign drop_hdr_cnt = '0;
    assign drop_ovf_cnt = '0;
`endif
endmodule

// File: rtl/mesh_src_port_bank.sv
// mesh_src_port_bank: per-terminal ingress FIFO bank with header validation; MESH_SRC_STATS_EN enables drop counters
module mesh_src_port_bank
    import mesh_pkg::*;
#(
    parameter int         ROWS       = 4,
    parameter int         COLUMS     = 4,
    parameter int         PCKG_SZ    = 40,
    parameter int         FIFO_DEPTH = 4,
    parameter int         NTERM      = 2*ROWS + 2*COLUMS,
    parameter logic [7:0] BDCST      = BDCST_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NTERM-1:0]           push,
    input  logic [NTERM*PCKG_SZ-1:0]   push_data,
    input  logic [NTERM-1:0]           flush,
    output logic [NTERM-1:0]           full,
    output logic [NTERM-1:0]           pndng_i_in,
    output logic [NTERM*PCKG_SZ-1:0]   data_out_i_in,
    input  logic [NTERM-1:0]           popin,
    output logic [NTERM-1:0]           hdr_err,
    output logic [NTERM-1:0]           ovf,
    output logic [NTERM-1:0]           unf_sticky,
    output logic [NTERM*8-1:0]         drop_hdr_cnt,
    output logic [NTERM*8-1:0]         drop_ovf_cnt
);
    localparam int NM = NXTJP_MSB(PCKG_SZ);
    localparam int RM = ROW_MSB(PCKG_SZ);
    localparam int CM = COL_MSB(PCKG_SZ);
    genvar i;
    generate
        for (i = 0; i < NTERM; i++) begin : g_ch
            logic hdr_ok;
            assign hdr_ok = dest_valid(push_data[i*PCKG_SZ+RM -: 4], push_data[i*PCKG_SZ+CM -: 4],
                                       push_data[i*PCKG_SZ+NM -: 8], ROWS, COLUMS, BDCST);
            mesh_src_fifo #(.PCKG_SZ(PCKG_SZ), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
                .clk          (clk),
                .reset        (reset),
                .push         (push[i]),
                .hdr_ok       (hdr_ok),
                .popin        (popin[i]),
                .flush        (flush[i]),
                .din          (push_data[i*PCKG_SZ +: PCKG_SZ]),
                .full         (full[i]),
                .pndng        (pndng_i_in[i]),
                .hdr_err      (hdr_err[i]),
                .ovf          (ovf[i]),
                .unf_sticky   (unf_sticky[i]),
                .dout         (data_out_i_in[i*PCKG_SZ +: PCKG_SZ]),
                .drop_hdr_cnt (drop_hdr_cnt[i*8 +: 8]),
                .drop_ovf_cnt (drop_ovf_cnt[i*8 +: 8])
            );
        end
    endgenerate
endmodule

// File: tb/tb_mesh_src_port_bank.sv
// tb_mesh_src_port_bank: queue-model scoreboard bench for the mesh source port bank
module tb_mesh_src_port_bank;
    localparam int R = 4, C = 4, W = 40, D = 4, N = 16;
    logic clk = 1'b0;
    logic reset;
    logic [N-1:0] push, flush, popin, full, pndng, hdr_err, ovf, unf;
    logic [N*W-1:0] push_data, data_out;
    logic [N*8-1:0] dh, dov;
    mesh_src_port_bank #(.ROWS(R), .COLUMS(C), .PCKG_SZ(W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data), .flush(flush),
        .full(full), .pndng_i_in(pndng), .data_out_i_in(data_out), .popin(popin),
        .hdr_err(hdr_err), .ovf(ovf), .unf_sticky(unf), .drop_hdr_cnt(dh), .drop_ovf_cnt(dov)
    );
    always #5 clk = ~clk;
    logic [W-1:0] mq [N][$];
    logic [W-1:0] sbq [N][$];
    logic [W-1:0] nd [N];
    logic [N-1:0] np, npop, nf;
    bit e_hdr [N], e_ovf [N], e_unf [N];
    int e_dh [N], e_do [N];
    int checks = 0, failures = 0;

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, a, e, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(int nx, int r, int c, int md, int pay);
        logic [W-1:0] w;
        w = '0;
        w[39:32] = nx[7:0];
        w[31:28] = r[3:0];
        w[27:24] = c[3:0];
        w[23] = md[0];
        w[22:0] = pay[22:0];
        return w;
    endfunction

    function automatic bit hv(logic [W-1:0] w);
        int nx, r, c;
        nx = int'(w[39:32]);
        r = int'(w[31:28]);
        c = int'(w[27:24]);
        if (nx == 255) return 1;
        if ((r == 0 || r == R + 1) && c >= 1 && c <= C) return 1;
        if ((c == 0 || c == C + 1) && r >= 1 && r <= R) return 1;
        return 0;
    endfunction

    function automatic logic [W-1:0] rnd_word();
        int nx;
        nx = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 254));
        return mk(nx, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 1)), int'($urandom));
    endfunction

    task automatic check_flags();
        logic [N-1:0] ep, ef, eh, eo, eu;
        for (int c = 0; c < N; c++) begin
            ep[c] = mq[c].size() != 0;
            ef[c] = mq[c].size() == D;
            eh[c] = e_hdr[c];
            eo[c] = e_ovf[c];
            eu[c] = e_unf[c];
        end
        chk("pndng", 64'(pndng), 64'(ep));
        chk("full", 64'(full), 64'(ef));
        chk("hdr_err", 64'(hdr_err), 64'(eh));
        chk("ovf", 64'(ovf), 64'(eo));
        chk("unf_sticky", 64'(unf), 64'(eu));
        for (int c = 0; c < N; c++) begin
`ifdef MESH_SRC_STATS_EN
            chk("drop_hdr_cnt", 64'(dh[c*8 +: 8]), 64'(e_dh[c]));
            chk("drop_ovf_cnt", 64'(dov[c*8 +: 8]), 64'(e_do[c]));
`else
            chk("drop_hdr_cnt", 64'(dh[c*8 +: 8]), 64'd0);
            chk("drop_ovf_cnt", 64'(dov[c*8 +: 8]), 64'd0);
`endif
        end
    endtask

    task automatic step();
        bit v;
        int n;
        @(posedge clk);
        #1;
        check_flags();
        push = np;
        popin = npop;
        flush = nf;
        for (int c = 0; c < N; c++) push_data[c*W +: W] = nd[c];
        for (int c = 0; c < N; c++) begin
            e_hdr[c] = 0;
            e_ovf[c] = 0;
            if (nf[c]) begin
                mq[c].delete();
                e_unf[c] = 0;
            end else begin
                v = hv(nd[c]);
                n = mq[c].size();
                if (np[c] && !v) begin
                    e_hdr[c] = 1;
                    if (e_dh[c] < 255) e_dh[c]++;
                end
                if (np[c] && v && n == D && !npop[c]) begin
                    e_ovf[c] = 1;
                    if (e_do[c] < 255) e_do[c]++;
                end
                if (npop[c]) begin
                    if (n == 0) e_unf[c] = 1;
                    else sbq[c].push_back(mq[c].pop_front());
                end
                if (np[c] && v && (n < D || npop[c])) mq[c].push_back(nd[c]);
            end
        end
        np = '0;
        npop = '0;
        nf = '0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            mq[c].delete();
            sbq[c].delete();
            e_hdr[c] = 0;
            e_ovf[c] = 0;
            e_unf[c] = 0;
            e_dh[c] = 0;
            e_do[c] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < N; c++) begin
                if (popin[c] && !flush[c] && pndng[c]) begin
                    if (sbq[c].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL pop_unexpected ch=%0d actual=%h required=none", c, data_out[c*W +: W]);
                    end else chk($sformatf("pop_data_ch%0d", c), 64'(data_out[c*W +: W]), 64'(sbq[c].pop_front()));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        push = '0; popin = '0; flush = '0; push_data = '0;
        np = '0; npop = '0; nf = '0;
        for (int c = 0; c < N; c++) nd[c] = '0;
        model_reset();
        #12;
        chk("rst_pndng", 64'(pndng), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_dout", 64'(|data_out), 64'd0);
        chk("rst_pulses", 64'(hdr_err | ovf | unf), 64'd0);
        chk("rst_cnt", 64'(|{dh, dov}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        // ch3 single word round trip
        nd[3] = mk(0, 2, 0, 1, 1); np[3] = 1; step();
        step();
        npop[3] = 1; step();
        step();
        // ch0 fill, overflow, drain
        for (int k = 1; k <= 5; k++) begin nd[0] = mk(0, 0, 1 + (k % 4), 0, k); np[0] = 1; step(); end
        for (int k = 0; k < 4; k++) begin npop[0] = 1; step(); end
        step();
        // ch5 corner rejected, broadcast corner accepted
        nd[5] = mk(0, 0, 0, 0, 7); np[5] = 1; step();
        nd[5] = mk(255, 0, 0, 0, 8); np[5] = 1; step();
        npop[5] = 1; step();
        // ch7 full then simultaneous push and pop
        for (int k = 1; k <= 4; k++) begin nd[7] = mk(0, 5, 2, 0, 70 + k); np[7] = 1; step(); end
        nd[7] = mk(0, 5, 3, 0, 75); np[7] = 1; npop[7] = 1; step();
        for (int k = 0; k < 4; k++) begin npop[7] = 1; step(); end
        // ch2 underflow sticky then flush; interior address rejected
        npop[2] = 1; step();
        step(); step();
        nf[2] = 1; step();
        nd[4] = mk(0, 2, 2, 0, 9); np[4] = 1; step();
        step();
        // randomized traffic on all channels
        for (int t = 0; t < 2000; t++) begin
            for (int c = 0; c < N; c++) begin
                np[c] = $urandom_range(0, 99) < 45;
                nd[c] = rnd_word();
                nf[c] = $urandom_range(0, 99) < 3;
                npop[c] = !nf[c] && ($urandom_range(0, 99) < 35);
            end
            step();
        end
        step();
        // ch9 saturating overflow drops, counters survive flush
        nf[9] = 1; step();
        for (int k = 1; k <= 4; k++) begin nd[9] = mk(0, 1, 5, 0, k); np[9] = 1; step(); end
        for (int k = 0; k < 300; k++) begin nd[9] = mk(0, 1, 5, 0, 500 + k); np[9] = 1; step(); end
        nf[9] = 1; step();
        step();
        // ch1 reset with entries held
        for (int k = 1; k <= 3; k++) begin nd[1] = mk(0, 3, 0, 0, k); np[1] = 1; step(); end
        step();
        chk("pre_rst_pndng1", 64'(pndng[1]), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_rst_pndng", 64'(pndng), 64'd0);
        chk("async_rst_full", 64'(full), 64'd0);
        chk("async_rst_dout", 64'(|data_out), 64'd0);
        chk("async_rst_cnt", 64'(|{dh, dov}), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step();
        step();
        for (int c = 0; c < N; c++) chk("sb_drained", 64'(sbq[c].size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mesh_src_port_bank.md
Name: mesh_src_port_bank

Overview:
- Synthesizable ingress buffer bank feeding every terminal of the mesh_gnrtr router; parametrised successor of the single-depth terminal FIFO model.
- Holds one FIFO per terminal and presents pndng_i_in/data_out_i_in to the router, which pops via popin.
- Adds destination-header validation, overflow/underflow handling and per-channel flush, none of which the previous model had.

Parameters:
- ROWS, 4, mesh rows
- COLUMS, 4, mesh columns
- PCKG_SZ, 40, packet width in bits (minimum 18)
- FIFO_DEPTH, 4, entries per channel (power of two, minimum 2)
- NTERM, 2*ROWS+2*COLUMS, number of terminal channels
- BDCST, 8'hFF, broadcast Nxtjp value

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- push  in  NTERM  per-channel write strobe
- push_data  in  NTERM*PCKG_SZ  write data; channel i at [i*PCKG_SZ +: PCKG_SZ]
- flush  in  NTERM  synchronous per-channel clear
- full  out  NTERM  channel holds FIFO_DEPTH entries
- pndng_i_in  out  NTERM  channel not empty
- data_out_i_in  out  NTERM*PCKG_SZ  head entry per channel
- popin  in  NTERM  router pop, one per channel
- hdr_err  out  NTERM  one-cycle pulse: push rejected for bad header
- ovf  out  NTERM  one-cycle pulse: push rejected because channel full
- unf_sticky  out  NTERM  set by popin while empty; cleared by flush or reset
- drop_hdr_cnt  out  NTERM*8  saturating counters (optional feature)
- drop_ovf_cnt  out  NTERM*8  saturating counters (optional feature)

Behaviour:
- Reset: pointers and count = 0. full=0, pndng_i_in=0, data_out_i_in=0, hdr_err=0, ovf=0, unf_sticky=0, counters=0.
- Header fields:
  - Nxtjp [PCKG_SZ-1:PCKG_SZ-8]
  - row [PCKG_SZ-9:PCKG_SZ-12]
  - col [PCKG_SZ-13:PCKG_SZ-16]
  - mode [PCKG_SZ-17]
- Header valid iff any of:
  - Nxtjp==BDCST;
  - (row==0 or row==ROWS+1) and 1<=col<=COLUMS;
  - (col==0 or col==COLUMS+1) and 1<=row<=ROWS.
  - Corners and interior addresses are invalid.
- Push accepted iff push, header valid, and (count<FIFO_DEPTH or popin in the same cycle). Data is stored unmodified.
- Invalid header: entry dropped, hdr_err pulses the next cycle. Header error takes priority over overflow.
- Valid header while full and no popin: entry dropped, ovf pulses the next cycle.
- Latency:
  - pndng_i_in rises the cycle after an accepted push into an empty channel; no bypass.
  - data_out_i_in is registered-memory head; it updates the cycle after popin.
- popin while count==0: no pointer change, unf_sticky set.
- Simultaneous push and popin with count==0: push accepted, pop counts as underflow.
- Pointers wrap modulo FIFO_DEPTH. count width is $clog2(FIFO_DEPTH)+1.
- flush overrides push/popin in the same cycle: count=0, pointers=0, unf_sticky=0.
- Channels are fully independent; no arbitration between them.
- Reset mid-operation discards all contents immediately (asynchronous).

Optional Feature:
- MESH_SRC_STATS_EN defined: drop_hdr_cnt and drop_ovf_cnt increment per drop and saturate at 255. They are not cleared by flush, only by reset.
- Undefined: both ports are driven constant 0 and no counter flops are inferred.

Decomposition:
- Package mesh_pkg:
  - field offset functions taking PCKG_SZ (NXTJP_MSB, ROW_MSB, COL_MSB, MODE_BIT);
  - default BDCST;
  - function dest_valid(row, col, nxtjp, ROWS, COLUMS).
- Sub-module mesh_src_fifo: one channel with pointers, count, flags, unf_sticky and optional counters. It is instantiated NTERM times via generate. The bank level holds only header checking and bus slicing.

Test Plan (ROWS=4, COLUMS=4, PCKG_SZ=40, FIFO_DEPTH=4):
- Ch3 push Nxtjp=0,row=2,col=0,mode=1,payload=1 -> pndng_i_in[3]=1 next cycle; data_out_i_in ch3 equals the pushed word; popin -> pndng_i_in[3]=0 next cycle.
- Ch0 five valid pushes, no pops -> full[0]=1 after the 4th; 5th gives ovf[0] pulse; pops return words 1-4 in order.
- Ch5 push row=0,col=0 (corner) -> hdr_err[5] pulse, pndng stays 0. Push Nxtjp=8'hFF,row=0,col=0 -> accepted.
- Ch7 full, then push+popin in the same cycle -> count stays 4, no ovf; head advances to the 2nd word.
- Ch2 popin while empty -> unf_sticky[2]=1 and held; flush[2] -> cleared. Reset asserted with 3 entries in ch1 -> pndng_i_in[1]=0 immediately.
- With MESH_SRC_STATS_EN: 300 overflow drops on ch9 -> drop_ovf_cnt ch9 = 255. Without the macro -> reads 0.
